// File: rtl/approx1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx1_pkg
// Purpose  : Shared widths, operand/product types and the column-OR helper
//            for the approx1 approximate multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package approx1_pkg;

    localparam int OP_W            = 8;
    localparam int RES_W           = 16;
    localparam int APPROX_COLS_DEF = 4;

    typedef logic [OP_W-1:0]  operand_t;
    typedef logic [RES_W-1:0] product_t;

    // OR of every partial product a[i]&b[j] that lands in column k.
    function automatic logic col_or(input operand_t a, input operand_t b, input int k);
        logic r;
        r = 1'b0;
        for (int i = 0; i < OP_W; i++) begin
            if ((k - i) >= 0 && (k - i) < OP_W) begin
                r = r | (a[3'(i)] & b[3'(k - i)]);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx1_ppa.sv
`default_nettype none
// ============================================================================
// Module   : approx1_ppa
// Purpose  : Combinational partial-product array: OR-compressed low columns,
//            exact carry-save summation of the remaining columns.
// Revision : 1.0 - initial release
// ============================================================================
module approx1_ppa
    import approx1_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEF
) (
    input  operand_t a,
    input  operand_t b,
    output product_t c
);

    localparam product_t c_lo_mask = product_t'((32'd1 << APPROX_COLS) - 32'd1);

    product_t w_row [OP_W];
    product_t w_sum [OP_W-1];
    product_t w_cry [OP_W-1];
    product_t w_high;
    product_t w_low;

    // Each row holds one multiplier bit's partial products, low columns removed.
    generate
        for (genvar i = 0; i < OP_W; i++) begin : g_row
            assign w_row[i] = (product_t'(a & {OP_W{b[i]}}) << i) & ~c_lo_mask;
        end
    endgenerate

    assign w_sum[0] = w_row[0];
    assign w_cry[0] = w_row[1];

    // Linear 3:2 chain; the true total fits in 16 bits, so dropping the
    // carry out of bit 15 keeps the final sum exact.
    generate
        for (genvar k = 0; k < OP_W - 2; k++) begin : g_csa
            assign w_sum[k+1] = w_sum[k] ^ w_cry[k] ^ w_row[k+2];
            assign w_cry[k+1] = ((w_sum[k] & w_cry[k]) |
                                 (w_sum[k] & w_row[k+2]) |
                                 (w_cry[k] & w_row[k+2])) << 1;
        end
    endgenerate

    assign w_high = w_sum[OP_W-2] + w_cry[OP_W-2];

    generate
        for (genvar k = 0; k < RES_W; k++) begin : g_col
            if (k < APPROX_COLS) begin : g_or
                assign w_low[k] = col_or(a, b, k);
            end else begin : g_exact
                assign w_low[k] = 1'b0;
            end
        end
    endgenerate

    assign c = w_high | w_low;

endmodule
`default_nettype wire

// File: rtl/approx1.sv
`default_nettype none
// ============================================================================
// Module   : approx1
// Purpose  : 8x8 unsigned approximate multiplier, registered output.
//            Define APPROX1_PIPE_EN to add an input register stage (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
module approx1
    import approx1_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    output logic [RES_W-1:0]  c
);

    operand_t w_a;
    operand_t w_b;
    logic     w_valid;
    product_t w_prod;
    product_t r_c;
    logic     r_out_valid;

`ifdef APPROX1_PIPE_EN
    operand_t r_a;
    operand_t r_b;
    logic     r_in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_in_valid <= 1'b0;
        end else begin
            r_a        <= a;
            r_b        <= b;
            r_in_valid <= in_valid;
        end
    end

    assign w_a     = r_a;
    assign w_b     = r_b;
    assign w_valid = r_in_valid;
`else
    assign w_a     = a;
    assign w_b     = b;
    assign w_valid = in_valid;
`endif

    approx1_ppa #(
        .APPROX_COLS (APPROX_COLS)
    ) u_ppa (
        .a (w_a),
        .b (w_b),
        .c (w_prod)
    );

    // c holds its last result across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_valid;
            if (w_valid) begin
                r_c <= w_prod;
            end
        end
    end

    assign c         = r_c;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_approx1.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx1
// Purpose  : Self-checking bench for approx1 (APPROX_COLS=4 and exact =0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx1;

`ifdef APPROX1_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp4;
        logic [15:0] exp0;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        logic [15:0] prod;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid4;
    logic [15:0] c4;
    logic        out_valid0;
    logic [15:0] c0;

    int checks = 0;
    int errors = 0;

    sb_t q4[$];
    sb_t q0[$];

    always #5 clk = ~clk;

    approx1 #(.APPROX_COLS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid4),
        .c         (c4)
    );

    approx1 #(.APPROX_COLS(0)) dut_exact (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid0),
        .c         (c0)
    );

    // Bit-level reference: exact sum of high partial products, OR of low ones.
    function automatic logic [15:0] ref_approx(input logic [7:0] x, input logic [7:0] y, input int cols);
        int          h;
        logic [15:0] l;
        h = 0;
        l = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (x[i] & y[j]) begin
                    if (i + j < cols) l[i+j] = 1'b1;
                    else              h = h + (1 << (i + j));
                end
            end
        end
        return h[15:0] | l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; inputs are sampled by the following posedge.
    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e4);
        sb_t s;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        s.a      = x;
        s.b      = y;
        s.prod   = 16'({8'd0, x} * {8'd0, y});
        s.exp    = e4;
        q4.push_back(s);
        s.exp    = s.prod;
        q0.push_back(s);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        sb_t e;
        #1;
        if (out_valid4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL sb4_unexpected: got c=%0d expected no output", c4);
            end else begin
                e = q4.pop_front();
                if (c4 !== e.exp) begin
                    errors++;
                    $display("FAIL sb4 a=%0d b=%0d: got %0d expected %0d", e.a, e.b, c4, e.exp);
                end
                checks++;
                if (c4 > e.prod) begin
                    errors++;
                    $display("FAIL le_exact a=%0d b=%0d: got %0d expected <= %0d", e.a, e.b, c4, e.prod);
                end
            end
        end
        if (out_valid0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_unexpected: got c=%0d expected no output", c0);
            end else begin
                e = q0.pop_front();
                if (c0 !== e.exp) begin
                    errors++;
                    $display("FAIL sb0 a=%0d b=%0d: got %0d expected %0d", e.a, e.b, c0, e.exp);
                end
            end
        end
    end

    vec_t tbl [8];

    initial begin
        tbl[0] = '{a: 8'd0,   b: 8'd173, exp4: 16'd0,     exp0: 16'd0};
        tbl[1] = '{a: 8'd16,  b: 8'd16,  exp4: 16'd256,   exp0: 16'd256};
        tbl[2] = '{a: 8'd3,   b: 8'd3,   exp4: 16'd7,     exp0: 16'd9};
        tbl[3] = '{a: 8'd255, b: 8'd255, exp4: 16'd64991, exp0: 16'd65025};
        tbl[4] = '{a: 8'd200, b: 8'd100, exp4: 16'd20000, exp0: 16'd20000};
        tbl[5] = '{a: 8'd173, b: 8'd0,   exp4: 16'd0,     exp0: 16'd0};
        tbl[6] = '{a: 8'd1,   b: 8'd1,   exp4: 16'd1,     exp0: 16'd1};
        tbl[7] = '{a: 8'd9,   b: 8'd9,   exp4: 16'd73,    exp0: 16'd81};

        // Reset, with in_valid asserted during the second half.
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'd5;
        b        = 8'd7;
        repeat (2) @(negedge clk);
        chk("rst_c4",     32'(c4),         32'd0);
        chk("rst_valid4", 32'(out_valid4), 32'd0);
        chk("rst_c0",     32'(c0),         32'd0);
        chk("rst_valid0", 32'(out_valid0), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        // Table vectors back-to-back.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].exp4);
            if (tbl[i].exp0 != 16'({8'd0, tbl[i].a} * {8'd0, tbl[i].b}))
                $display("table entry %0d has inconsistent exact value", i);
        end
        in_valid = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk("hold_valid4", 32'(out_valid4), 32'd0);
        chk("hold_c4",     32'(c4),         32'd73);
        chk("hold_c0",     32'(c0),         32'd81);

        // Reset mid-stream drops the in-flight result.
        drive(8'd255, 8'd255, 16'd64991);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'd200;
        b        = 8'd100;
        q4.delete();
        q0.delete();
        @(negedge clk);
        chk("midrst_valid4", 32'(out_valid4), 32'd0);
        chk("midrst_c4",     32'(c4),         32'd0);
        chk("midrst_c0",     32'(c0),         32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk("midrst_quiet", 32'(out_valid4 | out_valid0), 32'd0);

        // Exhaustive sweep, back-to-back.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] idx;
            idx = 16'(i);
            drive(idx[15:8], idx[7:0], ref_approx(idx[15:8], idx[7:0], 4));
        end
        in_valid = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk("sweep_drain4", 32'(q4.size()),   32'd0);
        chk("sweep_drain0", 32'(q0.size()),   32'd0);
        chk("end_valid4",   32'(out_valid4),  32'd0);
        chk("end_hold_c4",  32'(c4),          32'd64991);
        chk("end_hold_c0",  32'(c0),          32'd65025);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
